// File: rtl/div_ab.sv
// Fixed-point divider: recovers A = AB / B (AB in [4:-5], B in [0:-5]) as a saturated [2:-3] quotient.
// Optional macro DIV_AB_ROUND_EN computes one extra quotient bit and rounds half away from zero.
module div_ab (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] AB_in,
  input  logic [5:0] B_in,
  output logic [5:0] A_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  output logic       dz
);

`ifdef DIV_AB_ROUND_EN
  localparam int QW = 14;
`else
  localparam int QW = 13;
`endif
  localparam logic [3:0] LAST = 4'(QW - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg;
  logic [QW-1:0]   dq_reg;
  logic [5:0]      rem_reg;
  logic [5:0]      div_reg;
  logic            neg_reg;
  logic            ab_neg_reg;
  logic [5:0]      a_reg;
  logic            ovf_reg;
  logic            dz_reg;

  logic [9:0]      ab_mag;
  logic [5:0]      b_mag;
  logic [6:0]      trial;
  logic            trial_ge;
  logic [5:0]      rem_step;
  logic [12:0]     mag;
  logic [5:0]      a_fix;
  logic            ovf_fix;
  logic            dz_fix;

  assign ab_mag   = AB_in[9] ? -AB_in : AB_in;
  assign b_mag    = B_in[5] ? -B_in : B_in;

  // dq_reg shifts dividend bits out of the top while quotient bits enter at the bottom
  assign trial    = {rem_reg, dq_reg[QW-1]};
  assign trial_ge = trial >= {1'b0, div_reg};
  assign rem_step = trial_ge ? (trial[5:0] - div_reg) : trial[5:0];

`ifdef DIV_AB_ROUND_EN
  assign mag = dq_reg[13:1] + {12'd0, dq_reg[0]};
`else
  assign mag = dq_reg;
`endif

  always_comb begin
    a_fix   = 6'd0;
    ovf_fix = 1'b0;
    dz_fix  = 1'b0;
    if (div_reg == 6'd0) begin
      dz_fix = 1'b1;
      a_fix  = ab_neg_reg ? 6'h20 : 6'h1F;
    end else if (mag == 13'd0) begin
      a_fix = 6'd0;
    end else if (!neg_reg) begin
      if (mag > 13'd31) begin
        a_fix   = 6'h1F;
        ovf_fix = 1'b1;
      end else begin
        a_fix = mag[5:0];
      end
    end else begin
      if (mag > 13'd32) begin
        a_fix   = 6'h20;
        ovf_fix = 1'b1;
      end else begin
        a_fix = -mag[5:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      dq_reg     <= '0;
      rem_reg    <= 6'd0;
      div_reg    <= 6'd0;
      neg_reg    <= 1'b0;
      ab_neg_reg <= 1'b0;
      a_reg      <= 6'd0;
      ovf_reg    <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dq_reg     <= {ab_mag, {(QW-10){1'b0}}};
            rem_reg    <= 6'd0;
            div_reg    <= b_mag;
            neg_reg    <= AB_in[9] ^ B_in[5];
            ab_neg_reg <= AB_in[9];
            cnt_reg    <= 4'd0;
          end
        end
        CALC: begin
          dq_reg  <= {dq_reg[QW-2:0], trial_ge};
          rem_reg <= rem_step;
          cnt_reg <= cnt_reg + 4'd1;
        end
        FIX: begin
          a_reg   <= a_fix;
          ovf_reg <= ovf_fix;
          dz_reg  <= dz_fix;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign A_out     = a_reg;
  assign ovf       = ovf_reg;
  assign dz        = dz_reg;

endmodule
